apb_master: RTL

- APB requester (initiator) that turns a simple valid/ready command interface into APB4 transfers. Sits between a local controller (test sequencer, register engine) and an APB responder such as the team's 256-word APB memory slave.
- Generates the IDLE -> SETUP -> ACCESS sequence, honours responder wait states, and returns read data and error status on a one-cycle response strobe.
- Includes a wait-state timeout so that a hung responder cannot stall the local side.

---
 rtl/apb_master.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB4 requester: turns a valid/ready command stream into SETUP/ACCESS transfers,
// returning read data and error status on a one-cycle response strobe, with a wait-state timeout.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                psel_r, psel_s;
    logic                penable_r, penable_s;
    logic                pwrite_r, pwrite_s;
    logic [ADDR_W-1:0]   paddr_r, paddr_s;
    logic [DATA_W-1:0]   pwdata_r, pwdata_s;
    logic [STRB_W-1:0]   pstrb_r, pstrb_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
    logic                rsp_slverr_r, rsp_slverr_s;
    logic                rsp_timeout_r, rsp_timeout_s;
    logic                cmd_ready_s;
    logic                accept_s;
    logic                to_hit_s;

    // Command handshake: open in IDLE, and on the completion edge of ACCESS for back-to-back.
    always_comb begin
        cmd_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:   cmd_ready_s = 1'b1;
            ST_ACCESS: cmd_ready_s = pready;
            default:   cmd_ready_s = 1'b0;
        endcase
    end

    assign accept_s = cmd_valid & cmd_ready_s;
    assign to_hit_s = (TIMEOUT != 0) && (cnt_r == CNT_LAST);

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        psel_s        = psel_r;
        penable_s     = penable_r;
        pwrite_s      = pwrite_r;
        paddr_s       = paddr_r;
        pwdata_s      = pwdata_r;
        pstrb_s       = pstrb_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_slverr_s  = rsp_slverr_r;
        rsp_timeout_s = rsp_timeout_r;

        // Both accept points latch the command identically; reads keep the old pwdata.
        if (accept_s) begin
            paddr_s  = cmd_addr;
            pwrite_s = cmd_write;
            if (cmd_write) begin
                pwdata_s = cmd_wdata;
                pstrb_s  = cmd_strb;
            end else begin
                pwdata_s = pwdata_r;
                pstrb_s  = {STRB_W{1'b0}};
            end
        end else begin
            paddr_s  = paddr_r;
            pwrite_s = pwrite_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
                    state_s   = ST_SETUP;
                end else begin
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                end
            end
            ST_SETUP: begin
                penable_s = 1'b1;
                cnt_s     = {CNT_W{1'b0}};
                state_s   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = pwrite_r ? {DATA_W{1'b0}} : prdata;
                    rsp_slverr_s  = pslverr;
                    rsp_timeout_s = 1'b0;
                    cnt_s         = {CNT_W{1'b0}};
                    penable_s     = 1'b0;
                    if (accept_s) begin
                        psel_s  = 1'b1;
                        state_s = ST_SETUP;
                    end else begin
                        psel_s  = 1'b0;
                        state_s = ST_IDLE;
                    end
                end else if (to_hit_s) begin
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = {DATA_W{1'b0}};
                    rsp_slverr_s  = 1'b1;
                    rsp_timeout_s = 1'b1;
                    cnt_s         = {CNT_W{1'b0}};
                    psel_s        = 1'b0;
                    penable_s     = 1'b0;
                    state_s       = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                psel_s    = 1'b0;
                penable_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without a response.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= {ADDR_W{1'b0}};
            pwdata_r      <= {DATA_W{1'b0}};
            pstrb_r       <= {STRB_W{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            rsp_slverr_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            psel_r        <= psel_s;
            penable_r     <= penable_s;
            pwrite_r      <= pwrite_s;
            paddr_r       <= paddr_s;
            pwdata_r      <= pwdata_s;
            pstrb_r       <= pstrb_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_slverr_r  <= rsp_slverr_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

    assign cmd_ready   = cmd_ready_s;
    assign busy        = (state_r != ST_IDLE);
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;
    assign pstrb       = pstrb_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_slverr  = rsp_slverr_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule
